// File: rtl/simple_circuit_sequencer.sv
// simple_circuit_sequencer
//   Sweeps the eight {A,B,C} input vectors of the Simple_Circuit gate network,
//   holds each for SETTLE cycles, samples D/E and checks them against
//   D = (A&B) | ~C and E = ~C. Reports pass, an error count and a failure mask.
// Ports:
//   clock, reset (async, active-high)
//   start      : begin a sweep (only honoured in IDLE)
//   abort      : return to IDLE from any state, beats start
//   D_in, E_in : outputs of the circuit under test
//   A, B, C    : registered drive to the circuit under test
//   busy       : high in every state except IDLE
//   done       : one-cycle pulse when a sweep completes
//   pass       : last completed sweep had zero errors
//   err_count  : mismatching vectors in the current/last sweep
//   fail_mask  : bit v set when vector v = {A,B,C} mismatched
module simple_circuit_sequencer #(
  parameter int SETTLE = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic       D_in,
  input  logic       E_in,
  output logic       A,
  output logic       B,
  output logic       C,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
  output logic [7:0] fail_mask
);

  typedef enum logic [2:0] {
    S_IDLE, S_APPLY, S_SETTLE, S_SAMPLE, S_DONE
  } state_t;

  localparam logic [7:0] LP_CNT_LOAD = 8'(SETTLE - 1);

  state_t     r_state;
  logic [2:0] r_vec;
  logic [7:0] r_cnt;
  logic [2:0] r_abc;
  logic       r_busy;
  logic       r_done;
  logic       r_pass;
  logic [3:0] r_err;
  logic [7:0] r_mask;

  // Compare against the vector actually being driven, not r_vec.
  logic w_exp_d, w_exp_e, w_mis;
  assign w_exp_d = (r_abc[2] & r_abc[1]) | ~r_abc[0];
  assign w_exp_e = ~r_abc[0];
  assign w_mis   = (D_in != w_exp_d) || (E_in != w_exp_e);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_vec   <= 3'd0;
      r_cnt   <= 8'd0;
      r_abc   <= 3'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
      r_err   <= 4'd0;
      r_mask  <= 8'h00;
    end else begin
      r_done <= 1'b0;
      if (abort && r_state != S_IDLE) begin
        // Partial err/mask are kept for inspection; pass stays cleared.
        r_state <= S_IDLE;
        r_abc   <= 3'd0;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_abc <= 3'd0;
            if (start && !abort) begin
              r_state <= S_APPLY;
              r_vec   <= 3'd0;
              r_err   <= 4'd0;
              r_mask  <= 8'h00;
              r_pass  <= 1'b0;
              r_busy  <= 1'b1;
            end
          end
          S_APPLY: begin
            r_abc   <= r_vec;
            r_cnt   <= LP_CNT_LOAD;
            r_state <= S_SETTLE;
          end
          S_SETTLE: begin
            if (r_cnt == 8'd0) r_state <= S_SAMPLE;
            else               r_cnt   <= r_cnt - 8'd1;
          end
          S_SAMPLE: begin
            if (w_mis) begin
              r_err         <= r_err + 4'd1;
              r_mask[r_vec] <= 1'b1;
            end
            if (r_vec == 3'd7) begin
              // Pass must include this last sample's outcome.
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_pass  <= (r_err == 4'd0) && !w_mis;
              r_abc   <= 3'd0;
            end else begin
              r_vec   <= r_vec + 3'd1;
              r_state <= S_APPLY;
            end
          end
          S_DONE: begin
            r_state <= S_IDLE;
            r_abc   <= 3'd0;
            r_busy  <= 1'b0;
          end
          default: begin
            r_state <= S_IDLE;
            r_abc   <= 3'd0;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign {A, B, C}  = r_abc;
  assign busy       = r_busy;
  assign done       = r_done;
  assign pass       = r_pass;
  assign err_count  = r_err;
  assign fail_mask  = r_mask;

endmodule

// File: tb/tb_simple_circuit_sequencer.sv
module tb_simple_circuit_sequencer;
  localparam int SETTLE = 2;
  localparam int P      = SETTLE + 2;   // cycles per vector
  localparam int SWEEP  = 8 * P;        // start edge to DONE edge

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       D_in, E_in;
  logic       A, B, C, busy, done, pass;
  logic [3:0] err_count;
  logic [7:0] fail_mask;

  // Circuit-under-test model with injectable faults.
  logic [7:0] fd = 8'h00;   // per-vector D flip
  logic [7:0] fe = 8'h00;   // per-vector E flip
  logic       stuck = 1'b0; // E stuck at 0
  logic [2:0] abc;
  assign abc  = {A, B, C};
  assign D_in = ((A & B) | ~C) ^ fd[abc];
  assign E_in = stuck ? 1'b0 : (~C ^ fe[abc]);

  simple_circuit_sequencer #(.SETTLE(SETTLE)) dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort),
    .D_in(D_in), .E_in(E_in), .A(A), .B(B), .C(C),
    .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .fail_mask(fail_mask)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference ----------------
  // A sweep is described only by n = edges since the start edge.
  bit         m_act  = 1'b0;
  int         m_n    = 0;
  int         m_err  = 0;
  logic [7:0] m_mask = 8'h00;
  bit         m_pass = 1'b0;

  function automatic bit mism(input int v);
    logic [2:0] vv;
    vv = v[2:0];
    return fd[vv] | (stuck ? !vv[0] : fe[vv]);
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_act = 0; m_n = 0; m_err = 0; m_mask = 8'h00; m_pass = 0;
    end else if (m_act) begin
      if (abort || m_n == SWEEP) m_act = 0;
      else begin
        m_n++;
        if (m_n % P == 0) begin
          if (mism(m_n / P - 1)) begin
            m_err++;
            m_mask[m_n / P - 1] = 1'b1;
          end
          if (m_n == SWEEP) m_pass = (m_err == 0);
        end
      end
    end else if (start && !abort) begin
      m_act = 1; m_n = 0; m_err = 0; m_mask = 8'h00; m_pass = 0;
    end
  end

  always @(negedge clock) begin
    int ea;
    ea = (m_act && m_n >= 1 && m_n < SWEEP) ? (m_n - 1) / P : 0;
    chk("abc",       16'(abc),       16'(ea));
    chk("busy",      16'(busy),      16'(m_act));
    chk("done",      16'(done),      16'(m_act && m_n == SWEEP));
    chk("pass",      16'(pass),      16'(m_pass));
    chk("err_count", 16'(err_count), 16'(m_err));
    chk("fail_mask", 16'(fail_mask), 16'(m_mask));
  end

  // ---------------- stimulus ----------------
  // Pulse start, then walk the sweep. t = edges since the start edge.
  task automatic run_sweep(input int rp1, input int rp2, input int abort_at,
                           output int done_lat);
    done_lat = -1;
    @(negedge clock) start = 1'b1;
    @(negedge clock) start = 1'b0;
    for (int t = 1; t <= 200; t++) begin
      @(negedge clock);
      if (done && done_lat < 0) done_lat = t;
      if (!busy) break;
      if (t == 200) chk("sweep_timeout", 16'd1, 16'd0);
      start = (t == rp1 || t == rp2);
      abort = (t == abort_at);
    end
    start = 1'b0;
    abort = 1'b0;
    @(negedge clock);
  endtask

  initial begin
    int lat;
    repeat (2) @(negedge clock);
    chk("rst_abc",  16'(abc), 16'd0);
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_pass", 16'(pass), 16'd0);
    chk("rst_mask", 16'(fail_mask), 16'd0);
    reset = 1'b0;
    @(negedge clock);

    // clean sweep
    run_sweep(-1, -1, -1, lat);
    chk("clean_lat",  16'(lat), 16'(SWEEP));
    chk("clean_pass", 16'(pass), 16'd1);
    chk("clean_err",  16'(err_count), 16'd0);
    chk("clean_mask", 16'(fail_mask), 16'h00);

    // E stuck at 0: vectors with C=0 fail
    stuck = 1'b1;
    run_sweep(-1, -1, -1, lat);
    chk("estuck_mask", 16'(fail_mask), 16'h55);
    chk("estuck_err",  16'(err_count), 16'd4);
    chk("estuck_pass", 16'(pass), 16'd0);
    stuck = 1'b0;

    // D inverted everywhere
    fd = 8'hFF;
    run_sweep(-1, -1, -1, lat);
    chk("dinv_mask", 16'(fail_mask), 16'hFF);
    chk("dinv_err",  16'(err_count), 16'd8);
    chk("dinv_pass", 16'(pass), 16'd0);
    fd = 8'h00;

    // start re-pulsed while busy
    run_sweep(5, 20, -1, lat);
    chk("repulse_lat",  16'(lat), 16'(SWEEP));
    chk("repulse_pass", 16'(pass), 16'd1);
    chk("repulse_mask", 16'(fail_mask), 16'h00);

    // abort while vector 3 is driven
    run_sweep(-1, -1, 13, lat);
    chk("abort_nodone", 16'(lat == -1), 16'd1);
    chk("abort_busy",   16'(busy), 16'd0);
    chk("abort_abc",    16'(abc), 16'd0);
    chk("abort_pass",   16'(pass), 16'd0);
    run_sweep(-1, -1, -1, lat);
    chk("post_abort_pass", 16'(pass), 16'd1);

    // start+abort together in IDLE
    @(negedge clock) begin start = 1'b1; abort = 1'b1; end
    @(negedge clock) begin start = 1'b0; abort = 1'b0; end
    chk("start_abort_idle", 16'(busy), 16'd0);

    // async reset mid-SETTLE of vector 1, away from any edge
    @(negedge clock) start = 1'b1;
    @(negedge clock) start = 1'b0;
    repeat (6) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    chk("areset_abc",  16'(abc), 16'd0);
    chk("areset_busy", 16'(busy), 16'd0);
    chk("areset_err",  16'({done, pass, err_count, fail_mask}), 16'd0);
    @(negedge clock) reset = 1'b0;
    run_sweep(-1, -1, -1, lat);
    chk("post_reset_lat",  16'(lat), 16'(SWEEP));
    chk("post_reset_pass", 16'(pass), 16'd1);

    // randomized faults, re-pulses and aborts
    for (int i = 0; i < 24; i++) begin
      fd    = 8'($urandom);
      fe    = 8'($urandom);
      if ($urandom_range(0, 2) == 0) fd = 8'h00;
      if ($urandom_range(0, 2) == 0) fe = 8'h00;
      stuck = ($urandom_range(0, 3) == 0);
      run_sweep(int'($urandom_range(2, 30)), int'($urandom_range(2, 30)),
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 31)) : -1, lat);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/simple_circuit_sequencer.md
# simple_circuit_sequencer

Self-checking controller for the three-input Simple_Circuit gate network (inputs A, B, C; outputs D, E). On a start request it walks all eight input vectors, holds each for a programmable settle time, and samples D and E. It compares them against the golden functions D = (A·B) + C' and E = C', then reports pass/fail, an error count and a per-vector failure mask. It replaces the hand-written delay-based stimulus with a clocked, synthesizable sequencer that can sit on the lab board next to the circuit under test.

## Interface
- SETTLE, 2: cycles each vector is held before sampling; legal range 1..255.
- clock  in  1  rising-edge system clock
- reset  in  1  asynchronous, active-high; forces all state and outputs to reset values
- start  in  1  begin a sweep; sampled only in IDLE
- abort  in  1  synchronous; return to IDLE from any state; wins over start
- D_in  in  1  D output of the circuit under test
- E_in  in  1  E output of the circuit under test
- A, B, C  out  1 each  registered drive to the circuit under test
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at end of a completed sweep
- pass  out  1  high when the last completed sweep had zero errors
- err_count  out  4  mismatching vectors in the current/last sweep (0..8)
- fail_mask  out  8  bit v set when vector v = {A,B,C} mismatched

## Operation
- Reset values:
  - A = B = C = 0, busy = 0, done = 0, pass = 0.
  - err_count = 0, fail_mask = 8'h00.
  - State = IDLE, vector index vec = 0.
- FSM states: IDLE, APPLY, SETTLE, SAMPLE, DONE.
- IDLE:
  - {A,B,C} = 000.
  - start=1 and abort=0 → APPLY with vec = 0; err_count, fail_mask and pass are cleared.
- APPLY:
  - Registers {A,B,C} = vec and loads the settle counter with SETTLE-1.
  - Next state is SETTLE.
- SETTLE:
  - Holds {A,B,C} and decrements the counter.
  - Counter = 0 → SAMPLE.
- SAMPLE:
  - Compares D_in and E_in against (A&B)|~C and ~C of the currently driven vector.
  - On any mismatch: err_count += 1 and fail_mask[vec] = 1.
  - vec = 7 → DONE; otherwise vec += 1 → APPLY.
- DONE:
  - done = 1 for this cycle; pass = (final err_count == 0), registered.
  - {A,B,C} returns to 000; next state is IDLE.
- start while busy is ignored and has no side effects.
- abort in any non-IDLE state:
  - Next state is IDLE and {A,B,C} = 000.
  - No done pulse; pass is left cleared (0).
  - err_count and fail_mask keep their partial values.
- start and abort asserted together in IDLE: abort wins and the sweep does not start.
- vec is 3 bits and never wraps inside a sweep; the DONE transition is taken at vec = 7.
- err_count saturates naturally at 8; no overflow is possible in 4 bits.

## Timing
- Each vector occupies SETTLE+2 cycles: one APPLY, SETTLE cycles in SETTLE, one SAMPLE.
- With SETTLE=2 that is 4 cycles per vector.
- If start is sampled at edge k, DONE is entered at edge k + 8·(SETTLE+2); done is high for the following cycle only.
  - With SETTLE=2 this is edge k+32.
- The circuit under test sees each vector stable for SETTLE+1 full cycles before the sampling edge.
- busy rises the cycle after the start edge and falls on the cycle IDLE is re-entered.
- A new start is accepted on the first IDLE cycle after DONE.
- Asynchronous reset mid-sweep clears all outputs immediately, independent of clock.

## Test plan
- Golden model of the circuit, SETTLE=2, start pulse → {A,B,C} steps 000..111 at 4-cycle intervals; done 32 edges after start; pass=1, err_count=0, fail_mask=8'h00.
- E_in stuck at 0 → vectors 0, 2, 4, 6 fail; fail_mask=8'h55, err_count=4, pass=0.
- D_in inverted relative to golden → fail_mask=8'hFF, err_count=8, pass=0.
- start re-pulsed at cycles 5 and 20 of a sweep → exactly one done pulse at the original time; results identical to the clean run.
- abort while vec=3 → IDLE next cycle, {A,B,C}=000, busy=0, no done, pass=0; a following start runs a full clean sweep with pass=1.
- reset asserted mid-SETTLE, off a clock edge → all outputs 0 immediately; after release, start runs a correct sweep.
